// File: rtl/aha_tlx_rev_lane_checker_if.sv
// Control and status bundle between the REV lane checker and the TLX training controller.
interface aha_tlx_rev_lane_checker_if #(
    parameter int NUM_LANES = 3,
    parameter int ERR_CNT_W = 16
);
    logic                           ENABLE;
    logic                           CLR_ERR;
    logic [NUM_LANES-1:0]           LANE_IN;
    logic [2*NUM_LANES-1:0]         LANE_STATE;
    logic [NUM_LANES-1:0]           LANE_LOCKED;
    logic [NUM_LANES*ERR_CNT_W-1:0] LANE_ERR_CNT;
    logic                           ALL_LOCKED;
    logic                           LOCK_EVT;

    modport master (
        output ENABLE, CLR_ERR, LANE_IN,
        input  LANE_STATE, LANE_LOCKED, LANE_ERR_CNT, ALL_LOCKED, LOCK_EVT
    );
    modport slave (
        input  ENABLE, CLR_ERR, LANE_IN,
        output LANE_STATE, LANE_LOCKED, LANE_ERR_CNT, ALL_LOCKED, LOCK_EVT
    );
endinterface

// File: rtl/aha_tlx_rev_lane_checker.sv
// Per-lane self-seeding PRBS7 checker for TLX REV data lanes, with lock tracking and error counts.
// Optional loss-of-lock re-seed in LOCKED is enabled by defining AHA_TLX_REV_CHK_LOSS_EN.
module aha_tlx_rev_lane_checker_lane #(
    parameter int LOCK_CNT    = 64,
`ifdef AHA_TLX_REV_CHK_LOSS_EN
    parameter int LOSS_THRESH = 8,
`endif
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 clr_err_i,
    input  logic                 bit_i,
    output logic [1:0]           state_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    // One counter serves both the 7-bit seed count and the consecutive-match count.
    localparam int CNT_W = ($clog2(LOCK_CNT) > 3) ? $clog2(LOCK_CNT) : 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [6:0]           lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 locked_q;
    logic                 pred, miss;
    logic [6:0]           seed_shift;

    assign pred       = lfsr_q[6] ^ lfsr_q[5];
    assign miss       = bit_i ^ pred;
    assign seed_shift = {lfsr_q[5:0], bit_i};

`ifdef AHA_TLX_REV_CHK_LOSS_EN
    localparam int LOSS_W = $clog2(LOSS_THRESH + 1);
    logic [LOSS_W-1:0] loss_q, loss_d;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef AHA_TLX_REV_CHK_LOSS_EN
        loss_d  = loss_q;
`endif
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEED;
                    cnt_d   = '0;
                end
                ST_SEED: begin
                    lfsr_d = seed_shift;
                    if (cnt_q == CNT_W'(6)) begin
                        // An all-zero seed would lock the LFSR at zero forever.
                        cnt_d = '0;
                        if (seed_shift != 7'h00) state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    lfsr_d = {lfsr_q[5:0], pred};
                    if (miss) begin
                        state_d = ST_SEED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    lfsr_d = {lfsr_q[5:0], pred};
                    if (miss && (err_q != '1)) err_d = err_q + 1'b1;
`ifdef AHA_TLX_REV_CHK_LOSS_EN
                    if (!miss) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_W'(LOSS_THRESH - 1)) begin
                        state_d = ST_SEED;
                        cnt_d   = '0;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef AHA_TLX_REV_CHK_LOSS_EN
        if (state_d != ST_LOCKED) loss_d = '0;
`endif
        if (clr_err_i) err_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

`ifdef AHA_TLX_REV_CHK_LOSS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) loss_q <= '0;
        else         loss_q <= loss_d;
    end
`endif

    assign state_o   = state_q;
    assign locked_o  = locked_q;
    assign err_cnt_o = err_q;
endmodule

module aha_tlx_rev_lane_checker #(
    parameter int NUM_LANES   = 3,
    parameter int LOCK_CNT    = 64,
    parameter int ERR_CNT_W   = 16,
    parameter int LOSS_THRESH = 8
) (
    input  logic                       TLX_REV_CLK,
    input  logic                       TLX_REV_RESETn,
    aha_tlx_rev_lane_checker_if.slave  bus_io
);
    if (LOCK_CNT < 2 || LOSS_THRESH < 1) begin : g_param_range
        $error("aha_tlx_rev_lane_checker: LOCK_CNT must be >= 2 and LOSS_THRESH >= 1");
    end

    logic [NUM_LANES-1:0]                lane_locked;
    logic [NUM_LANES-1:0][1:0]           lane_state;
    logic [NUM_LANES-1:0][ERR_CNT_W-1:0] lane_err;
    logic                                all_locked;
    logic                                all_q, evt_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        aha_tlx_rev_lane_checker_lane #(
            .LOCK_CNT    (LOCK_CNT),
`ifdef AHA_TLX_REV_CHK_LOSS_EN
            .LOSS_THRESH (LOSS_THRESH),
`endif
            .ERR_CNT_W   (ERR_CNT_W)
        ) u_lane (
            .clk_i     (TLX_REV_CLK),
            .rst_ni    (TLX_REV_RESETn),
            .enable_i  (bus_io.ENABLE),
            .clr_err_i (bus_io.CLR_ERR),
            .bit_i     (bus_io.LANE_IN[i]),
            .state_o   (lane_state[i]),
            .locked_o  (lane_locked[i]),
            .err_cnt_o (lane_err[i])
        );
    end

    assign all_locked = &lane_locked;

    // Edge-detect ALL_LOCKED so the event fires once per rise.
    always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
        if (!TLX_REV_RESETn) begin
            all_q <= 1'b0;
            evt_q <= 1'b0;
        end else begin
            all_q <= all_locked;
            evt_q <= all_locked & ~all_q;
        end
    end

    assign bus_io.LANE_STATE   = lane_state;
    assign bus_io.LANE_LOCKED  = lane_locked;
    assign bus_io.LANE_ERR_CNT = lane_err;
    assign bus_io.ALL_LOCKED   = all_locked;
    assign bus_io.LOCK_EVT     = evt_q;
endmodule

// File: tb/tb_aha_tlx_rev_lane_checker.sv
// Directed bench for the REV lane checker: a 16-bit-counter instance plus a 4-bit one sharing the lanes.
module tb_aha_tlx_rev_lane_checker;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aha_tlx_rev_lane_checker_if #(.NUM_LANES(NL), .ERR_CNT_W(16)) ifc ();
    aha_tlx_rev_lane_checker_if #(.NUM_LANES(NL), .ERR_CNT_W(4))  ifc4 ();

    aha_tlx_rev_lane_checker #(.NUM_LANES(NL), .LOCK_CNT(64), .ERR_CNT_W(16), .LOSS_THRESH(8)) dut (
        .TLX_REV_CLK(clk), .TLX_REV_RESETn(rst_n), .bus_io(ifc));
    aha_tlx_rev_lane_checker #(.NUM_LANES(NL), .LOCK_CNT(64), .ERR_CNT_W(4), .LOSS_THRESH(8)) dut4 (
        .TLX_REV_CLK(clk), .TLX_REV_RESETn(rst_n), .bus_io(ifc4));

    int checks = 0;
    int errors = 0;
    int evt_cnt = 0;

    // Independent PRBS7 source per lane: next bit = b[n-7] ^ b[n-6].
    logic [6:0]    gen [NL];
    logic [NL-1:0] clean, flip, zero;
    always_comb begin
        clean = '0;
        for (int i = 0; i < NL; i++) clean[i] = gen[i][6] ^ gen[i][5];
    end
    assign ifc.LANE_IN   = (clean ^ flip) & ~zero;
    assign ifc4.LANE_IN  = ifc.LANE_IN;
    assign ifc4.ENABLE   = ifc.ENABLE;

    function automatic logic [15:0] err16(input int i);
        return ifc.LANE_ERR_CNT[i*16 +: 16];
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) gen[i] = {gen[i][5:0], gen[i][6] ^ gen[i][5]};
            flip = '0;
            if (ifc.LOCK_EVT === 1'b1) evt_cnt++;
        end
    endtask

    task automatic test_reset();
        gen[0] = 7'h7F; gen[1] = 7'h15; gen[2] = 7'h4C;
        flip = '0; zero = '0;
        ifc.ENABLE = 1'b0; ifc.CLR_ERR = 1'b0; ifc4.CLR_ERR = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++; if (ifc.LANE_STATE !== 6'h00) begin errors++; $display("FAIL reset_state: got %h exp 00", ifc.LANE_STATE); end
        checks++; if (ifc.LANE_LOCKED !== 3'b000) begin errors++; $display("FAIL reset_locked: got %b exp 000", ifc.LANE_LOCKED); end
        checks++; if (ifc.LANE_ERR_CNT !== 48'h0) begin errors++; $display("FAIL reset_err: got %h exp 0", ifc.LANE_ERR_CNT); end
        checks++; if ({ifc.ALL_LOCKED, ifc.LOCK_EVT} !== 2'b00) begin errors++; $display("FAIL reset_all_evt: got %b exp 00", {ifc.ALL_LOCKED, ifc.LOCK_EVT}); end
        @(negedge clk); rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_lock();
        ifc.ENABLE = 1'b1; evt_cnt = 0;
        tick(71);  // edges 0..70
        checks++; if (ifc.LANE_STATE !== 6'b101010) begin errors++; $display("FAIL lock_pre_state: got %b exp 101010", ifc.LANE_STATE); end
        checks++; if (ifc.LANE_LOCKED !== 3'b000) begin errors++; $display("FAIL lock_pre_locked: got %b exp 000", ifc.LANE_LOCKED); end
        tick(1);   // edge 71
        checks++; if (ifc.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL lock_locked: got %b exp 111", ifc.LANE_LOCKED); end
        checks++; if (ifc.ALL_LOCKED !== 1'b1) begin errors++; $display("FAIL lock_all: got %b exp 1", ifc.ALL_LOCKED); end
        checks++; if (ifc.LANE_STATE !== 6'b111111) begin errors++; $display("FAIL lock_state: got %b exp 111111", ifc.LANE_STATE); end
        tick(4);
        checks++; if (evt_cnt !== 1) begin errors++; $display("FAIL lock_evt_count: got %0d exp 1", evt_cnt); end
        checks++; if (ifc.LANE_ERR_CNT !== 48'h0) begin errors++; $display("FAIL lock_err: got %h exp 0", ifc.LANE_ERR_CNT); end
        checks++; if (ifc4.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL lock_dut4: got %b exp 111", ifc4.LANE_LOCKED); end
    endtask

    task automatic test_err_count();
        for (int k = 0; k < 5; k++) begin
            flip = 3'b010; tick(1); tick(1);
        end
        checks++; if (err16(1) !== 16'd5) begin errors++; $display("FAIL err_lane1: got %0d exp 5", err16(1)); end
        checks++; if ({err16(0), err16(2)} !== 32'h0) begin errors++; $display("FAIL err_lane0_2: got %0d/%0d exp 0/0", err16(0), err16(2)); end
        checks++; if (ifc.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL err_lock_held: got %b exp 111", ifc.LANE_LOCKED); end
        checks++; if (ifc4.LANE_ERR_CNT[7:4] !== 4'd5) begin errors++; $display("FAIL err_dut4_lane1: got %0d exp 5", ifc4.LANE_ERR_CNT[7:4]); end
    endtask

    task automatic test_loss();
`ifdef AHA_TLX_REV_CHK_LOSS_EN
        for (int k = 0; k < 7; k++) begin flip = 3'b001; tick(1); end
        tick(1);
        checks++; if (ifc.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL loss_7_held: got %b exp 111", ifc.LANE_LOCKED); end
        checks++; if (err16(0) !== 16'd7) begin errors++; $display("FAIL loss_7_err: got %0d exp 7", err16(0)); end
        for (int k = 0; k < 8; k++) begin flip = 3'b001; tick(1); end
        checks++; if (ifc.LANE_STATE[1:0] !== 2'b01) begin errors++; $display("FAIL loss_8_state: got %b exp 01", ifc.LANE_STATE[1:0]); end
        checks++; if ({ifc.LANE_LOCKED, ifc.ALL_LOCKED} !== 4'b1100) begin errors++; $display("FAIL loss_8_lock: got %b exp 1100", {ifc.LANE_LOCKED, ifc.ALL_LOCKED}); end
        checks++; if (err16(0) !== 16'd15) begin errors++; $display("FAIL loss_8_err: got %0d exp 15", err16(0)); end
        tick(71);
        checks++; if (ifc.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL loss_relock: got %b exp 111", ifc.LANE_LOCKED); end
`else
        for (int k = 0; k < 8; k++) begin flip = 3'b001; tick(1); end
        checks++; if (ifc.LANE_LOCKED !== 3'b111) begin errors++; $display("FAIL noloss_held: got %b exp 111", ifc.LANE_LOCKED); end
        checks++; if (err16(0) !== 16'd8) begin errors++; $display("FAIL noloss_err: got %0d exp 8", err16(0)); end
`endif
    endtask

    task automatic test_sat_clear();
        for (int k = 0; k < 20; k++) begin
            flip = 3'b100; tick(1); tick(1);
        end
        checks++; if (ifc4.LANE_ERR_CNT[11:8] !== 4'hF) begin errors++; $display("FAIL sat_dut4: got %0d exp 15", ifc4.LANE_ERR_CNT[11:8]); end
        checks++; if (err16(2) !== 16'd20) begin errors++; $display("FAIL sat_main: got %0d exp 20", err16(2)); end
        ifc4.CLR_ERR = 1'b1; flip = 3'b100; tick(1); ifc4.CLR_ERR = 1'b0;
        checks++; if (ifc4.LANE_ERR_CNT !== 12'h000) begin errors++; $display("FAIL clr_wins: got %h exp 000", ifc4.LANE_ERR_CNT); end
        checks++; if (err16(2) !== 16'd21) begin errors++; $display("FAIL clr_other_dut: got %0d exp 21", err16(2)); end
        flip = 3'b100; tick(1);
        checks++; if (ifc4.LANE_ERR_CNT !== 12'h100) begin errors++; $display("FAIL clr_resume: got %h exp 100", ifc4.LANE_ERR_CNT); end
    endtask

    task automatic test_check_error();
        ifc.ENABLE = 1'b0; tick(1);
        checks++; if ({ifc.LANE_STATE, ifc.LANE_LOCKED, ifc.ALL_LOCKED} !== 10'h0) begin errors++; $display("FAIL dis_idle: got %b exp 0", {ifc.LANE_STATE, ifc.LANE_LOCKED, ifc.ALL_LOCKED}); end
        checks++; if (err16(2) !== 16'd22) begin errors++; $display("FAIL dis_err_hold: got %0d exp 22", err16(2)); end
        ifc.CLR_ERR = 1'b1; tick(1); ifc.CLR_ERR = 1'b0;
        checks++; if (ifc.LANE_ERR_CNT !== 48'h0) begin errors++; $display("FAIL clr_all: got %h exp 0", ifc.LANE_ERR_CNT); end
        ifc.ENABLE = 1'b1; evt_cnt = 0;
        tick(38);                     // edges 0..37: 30 matches in CHECK
        flip = 3'b100; tick(1);       // edge 38
        checks++; if (ifc.LANE_STATE !== 6'b011010) begin errors++; $display("FAIL chk_miss_state: got %b exp 011010", ifc.LANE_STATE); end
        tick(33);                     // edge 71
        checks++; if (ifc.LANE_LOCKED !== 3'b011) begin errors++; $display("FAIL chk_others_lock: got %b exp 011", ifc.LANE_LOCKED); end
        tick(37);                     // edge 108
        checks++; if (ifc.LANE_LOCKED !== 3'b011) begin errors++; $display("FAIL chk_lane2_early: got %b exp 011", ifc.LANE_LOCKED); end
        tick(1);                      // edge 109
        checks++; if ({ifc.LANE_LOCKED, ifc.ALL_LOCKED} !== 4'b1111) begin errors++; $display("FAIL chk_lane2_lock: got %b exp 1111", {ifc.LANE_LOCKED, ifc.ALL_LOCKED}); end
        tick(3);
        checks++; if (evt_cnt !== 1) begin errors++; $display("FAIL chk_evt: got %0d exp 1", evt_cnt); end
        checks++; if (ifc.LANE_ERR_CNT !== 48'h0) begin errors++; $display("FAIL chk_no_err: got %h exp 0", ifc.LANE_ERR_CNT); end
    endtask

    task automatic test_zero_lane();
        ifc.ENABLE = 1'b0; zero = 3'b001; tick(1);
        ifc.ENABLE = 1'b1; evt_cnt = 0;
        tick(20);                     // edges 0..19
        checks++; if (ifc.LANE_STATE !== 6'b101001) begin errors++; $display("FAIL zero_mid_state: got %b exp 101001", ifc.LANE_STATE); end
        ifc.ENABLE = 1'b0; tick(1);
        checks++; if ({ifc.LANE_STATE, ifc.LANE_LOCKED} !== 9'h0) begin errors++; $display("FAIL mid_check_drop: got %b exp 0", {ifc.LANE_STATE, ifc.LANE_LOCKED}); end
        ifc.ENABLE = 1'b1;
        tick(72);                     // edges 0..71
        checks++; if (ifc.LANE_LOCKED !== 3'b110) begin errors++; $display("FAIL zero_lock: got %b exp 110", ifc.LANE_LOCKED); end
        tick(200);
        checks++; if (ifc.LANE_STATE[1:0] !== 2'b01) begin errors++; $display("FAIL zero_seed_stuck: got %b exp 01", ifc.LANE_STATE[1:0]); end
        checks++; if (ifc.ALL_LOCKED !== 1'b0) begin errors++; $display("FAIL zero_all: got %b exp 0", ifc.ALL_LOCKED); end
        checks++; if (evt_cnt !== 0) begin errors++; $display("FAIL zero_evt: got %0d exp 0", evt_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_err_count();
        test_loss();
        test_sat_clear();
        test_check_error();
        test_zero_lane();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
